if_else_pipe_sel: RTL and testbench

IF_ELSE_PIPE_SEL -- requirements
Module: if_else_pipe_sel

---
 rtl/if_else_pipe_sel_pkg.sv | 18 +
 rtl/if_else_seg_sel.sv | 37 +++
 rtl/if_else_pipe_sel.sv | 130 +++++++++++++
 tb/tb_if_else_pipe_sel.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/if_else_pipe_sel_pkg.sv
// if_else_pipe_sel_pkg
//   Shared constants for the if/else pipelined select block:
//   condition-mode encodings, statistics counter width, default segment
//   slice width and a helper that returns the low bit of a segment slice.
package if_else_pipe_sel_pkg;

  localparam int MODE_PER_SEG = 0;
  localparam int MODE_GLOBAL  = 1;

  localparam int CNT_W        = 16;
  localparam int SEG_SLICE_W  = 32;

  // Low bit index of segment 'seg' in a packed array of 'width'-bit slices.
  function automatic int seg_lo(input int seg, input int width);
    return seg * width;
  endfunction

endpackage

// File: rtl/if_else_seg_sel.sv
// if_else_seg_sel
//   One segment of the stage-2 register: on load, captures if_data when
//   cond is high and else_data otherwise, along with the condition itself.
// Ports:
//   clk, reset (async, active low)
//   load        capture enable (stage-1 advance)
//   cond        condition for this segment
//   if_data     if-branch data
//   else_data   else-branch data
//   data        registered selected data
//   flag        registered condition
module if_else_seg_sel
  import if_else_pipe_sel_pkg::*;
#(
  parameter int WIDTH = SEG_SLICE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             cond,
  input  logic [WIDTH-1:0] if_data,
  input  logic [WIDTH-1:0] else_data,
  output logic [WIDTH-1:0] data,
  output logic             flag
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data <= '0;
      flag <= 1'b0;
    end else if (load) begin
      data <= cond ? if_data : else_data;
      flag <= cond;
    end
  end

endmodule

// File: rtl/if_else_pipe_sel.sv
// if_else_pipe_sel
//   Two-stage valid/ready pipeline that selects, per segment, between an
//   if-branch and an else-branch data word. Stage 1 registers both arrays
//   and the evaluated condition vector; stage 2 registers the selection.
//   Optional statistics counters: define IF_ELSE_PIPE_SEL_STATS_EN.
// Ports:
//   clk, reset (async, active low)
//   in_valid / in_ready         input handshake
//   input_bit                   condition source
//   array_ref_wire              if-branch data, segment i at [i*WIDTH +: WIDTH]
//   array_ref_m_wire            else-branch data, same packing
//   out_valid / out_ready       output handshake
//   segment_combine             selected data
//   cond_flags                  condition used per segment
//   sel_if_count/sel_else_count saturating selection counters (STATS_EN only)
module if_else_pipe_sel
  import if_else_pipe_sel_pkg::*;
#(
  parameter int               WIDTH     = SEG_SLICE_W,
  parameter int               SEGMENTS  = 4,
  parameter int               MODE      = MODE_PER_SEG,
  parameter logic [WIDTH-1:0] COND_MASK = WIDTH'(32'h0000_0001)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          input_bit,
  input  logic [SEGMENTS*WIDTH-1:0] array_ref_wire,
  input  logic [SEGMENTS*WIDTH-1:0] array_ref_m_wire,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEGMENTS*WIDTH-1:0] segment_combine,
  output logic [SEGMENTS-1:0]       cond_flags
`ifdef IF_ELSE_PIPE_SEL_STATS_EN
  ,
  output logic [CNT_W-1:0]          sel_if_count,
  output logic [CNT_W-1:0]          sel_else_count
`endif
);

  logic                      s1_valid;
  logic [SEGMENTS*WIDTH-1:0] s1_if;
  logic [SEGMENTS*WIDTH-1:0] s1_else;
  logic [SEGMENTS-1:0]       s1_cond;
  logic [SEGMENTS-1:0]       cond_eval;
  logic                      glob_cond;
  logic                      s1_adv;
  logic                      s2_accept;
  logic                      in_fire;

  // Both forms are computed so every input bit feeds logic in either mode.
  assign glob_cond = |(input_bit & COND_MASK);

  always_comb begin
    cond_eval = '0;
    if (MODE == MODE_GLOBAL) cond_eval = {SEGMENTS{glob_cond}};
    else                     cond_eval = input_bit[SEGMENTS-1:0];
  end

  assign s2_accept = out_valid & out_ready;
  assign s1_adv    = s1_valid & (~out_valid | out_ready);
  assign in_ready  = ~s1_valid | s1_adv;
  assign in_fire   = in_valid & in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_if    <= '0;
      s1_else  <= '0;
      s1_cond  <= '0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_if    <= array_ref_wire;
        s1_else  <= array_ref_m_wire;
        s1_cond  <= cond_eval;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage-2 valid: an advancing stage-1 beat overwrites whatever is leaving.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         out_valid <= 1'b0;
    else if (s1_adv)    out_valid <= 1'b1;
    else if (s2_accept) out_valid <= 1'b0;
  end

  for (genvar i = 0; i < SEGMENTS; i++) begin : g_seg
    if_else_seg_sel #(.WIDTH(WIDTH)) u_sel (
      .clk       (clk),
      .reset     (reset),
      .load      (s1_adv),
      .cond      (s1_cond[i]),
      .if_data   (s1_if[seg_lo(i, WIDTH) +: WIDTH]),
      .else_data (s1_else[seg_lo(i, WIDTH) +: WIDTH]),
      .data      (segment_combine[seg_lo(i, WIDTH) +: WIDTH]),
      .flag      (cond_flags[i])
    );
  end

`ifdef IF_ELSE_PIPE_SEL_STATS_EN
  logic [CNT_W-1:0] if_add;
  logic [CNT_W-1:0] else_add;
  logic [CNT_W:0]   if_sum;
  logic [CNT_W:0]   else_sum;

  always_comb begin
    if_add = '0;
    for (int i = 0; i < SEGMENTS; i++) if_add = if_add + CNT_W'(cond_flags[i]);
    else_add = CNT_W'(SEGMENTS) - if_add;
    if_sum   = {1'b0, sel_if_count} + {1'b0, if_add};
    else_sum = {1'b0, sel_else_count} + {1'b0, else_add};
  end

  // Carry out of the widened sum means the count would wrap: pin at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_if_count   <= '0;
      sel_else_count <= '0;
    end else if (s2_accept) begin
      sel_if_count   <= if_sum[CNT_W]   ? '1 : if_sum[CNT_W-1:0];
      sel_else_count <= else_sum[CNT_W] ? '1 : else_sum[CNT_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_if_else_pipe_sel.sv
// tb_if_else_pipe_sel
//   Three instances share stimulus: A (per-segment mode), B (global mode,
//   mask 32'h10) and C (global mode, mask 0). Directed vectors come from a
//   table; random traffic is checked against a queue-based reference model.
module tb_if_else_pipe_sel;

  localparam int W = 32;
  localparam int S = 4;
  localparam logic [127:0] IF_ALL   = {32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001, 32'hAAAA_0000};
  localparam logic [127:0] ELSE_ALL = {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000};

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         out_ready;
  logic [31:0]  input_bit;
  logic [127:0] if_d;
  logic [127:0] else_d;

  logic         ir_a, ir_b, ir_c;
  logic         ov_a, ov_b, ov_c;
  logic [127:0] sc_a, sc_b, sc_c;
  logic [3:0]   cf_a, cf_b, cf_c;
`ifdef IF_ELSE_PIPE_SEL_STATS_EN
  logic [15:0]  ic_a, ec_a, ic_b, ec_b, ic_c, ec_c;
`endif

  always #5 clk = ~clk;

  if_else_pipe_sel #(.WIDTH(W), .SEGMENTS(S), .MODE(0)) u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_a),
    .input_bit(input_bit), .array_ref_wire(if_d), .array_ref_m_wire(else_d),
    .out_valid(ov_a), .out_ready(out_ready), .segment_combine(sc_a), .cond_flags(cf_a)
`ifdef IF_ELSE_PIPE_SEL_STATS_EN
    , .sel_if_count(ic_a), .sel_else_count(ec_a)
`endif
  );

  if_else_pipe_sel #(.WIDTH(W), .SEGMENTS(S), .MODE(1), .COND_MASK(32'h10)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_b),
    .input_bit(input_bit), .array_ref_wire(if_d), .array_ref_m_wire(else_d),
    .out_valid(ov_b), .out_ready(out_ready), .segment_combine(sc_b), .cond_flags(cf_b)
`ifdef IF_ELSE_PIPE_SEL_STATS_EN
    , .sel_if_count(ic_b), .sel_else_count(ec_b)
`endif
  );

  if_else_pipe_sel #(.WIDTH(W), .SEGMENTS(S), .MODE(1), .COND_MASK(32'h0)) u_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_c),
    .input_bit(input_bit), .array_ref_wire(if_d), .array_ref_m_wire(else_d),
    .out_valid(ov_c), .out_ready(out_ready), .segment_combine(sc_c), .cond_flags(cf_c)
`ifdef IF_ELSE_PIPE_SEL_STATS_EN
    , .sel_if_count(ic_c), .sel_else_count(ec_c)
`endif
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0]  ibit;
    logic [127:0] ifd;
    logic [127:0] eld;
    int           ready;   // first edge count at which the beat may be visible
  } beat_t;

  beat_t q[$];
  int    cyc = 0;
  int    exp_ifc[3];
  int    exp_elc[3];

  // Conditions each instance should use, from its mode and mask.
  function automatic logic [3:0] flags_of(input int inst, input logic [31:0] ibit);
    case (inst)
      0:       return ibit[3:0];
      1:       return ((ibit & 32'h10) != 0) ? 4'b1111 : 4'b0000;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [127:0] sel_of(input logic [3:0] c, input logic [127:0] a,
                                          input logic [127:0] b);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = c[i] ? a[i*32 +: 32] : b[i*32 +: 32];
    return r;
  endfunction

  function automatic int sat_add(input int acc, input int add);
    return (acc + add > 65535) ? 65535 : acc + add;
  endfunction

  // One cycle: drive, check against the model, clock, advance the model.
  task automatic step(input logic iv, input logic orr, input logic [31:0] ib,
                      input logic [127:0] a, input logic [127:0] b, output logic acc);
    logic exp_ov, exp_ir, ofire;
    logic [3:0] f;
    in_valid = iv; out_ready = orr; input_bit = ib; if_d = a; else_d = b;
    #1;
    exp_ov = (q.size() > 0) && (cyc >= q[0].ready);
    exp_ir = !((q.size() == 2) && !orr);
    chk("in_ready_a", ir_a, exp_ir);
    chk("in_ready_b", ir_b, exp_ir);
    chk("out_valid_a", ov_a, exp_ov);
    chk("out_valid_b", ov_b, exp_ov);
    chk("out_valid_c", ov_c, exp_ov);
    if (exp_ov) begin
      f = flags_of(0, q[0].ibit);
      chk("flags_a", cf_a, f);
      chk("data_a", sc_a, sel_of(f, q[0].ifd, q[0].eld));
      f = flags_of(1, q[0].ibit);
      chk("flags_b", cf_b, f);
      chk("data_b", sc_b, sel_of(f, q[0].ifd, q[0].eld));
      chk("flags_c", cf_c, 4'b0000);
      chk("data_c", sc_c, q[0].eld);
    end
`ifdef IF_ELSE_PIPE_SEL_STATS_EN
    chk("if_cnt_a", ic_a, exp_ifc[0]);   chk("else_cnt_a", ec_a, exp_elc[0]);
    chk("if_cnt_b", ic_b, exp_ifc[1]);   chk("else_cnt_b", ec_b, exp_elc[1]);
    chk("if_cnt_c", ic_c, exp_ifc[2]);   chk("else_cnt_c", ec_c, exp_elc[2]);
`endif
    ofire = exp_ov && orr;
    acc   = iv && exp_ir;
    @(posedge clk);
    cyc++;
    if (ofire) begin
      for (int k = 0; k < 3; k++) begin
        exp_ifc[k] = sat_add(exp_ifc[k], $countones(flags_of(k, q[0].ibit)));
        exp_elc[k] = sat_add(exp_elc[k], 4 - $countones(flags_of(k, q[0].ibit)));
      end
      void'(q.pop_front());
    end
    if (acc) q.push_back('{ib, a, b, cyc + 1});
    #1;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_out_valid_a", ov_a, 1'b0);
    chk("rst_out_valid_b", ov_b, 1'b0);
    chk("rst_data_a", sc_a, '0);
    chk("rst_flags_a", cf_a, '0);
    chk("rst_in_ready_a", ir_a, 1'b1);
`ifdef IF_ELSE_PIPE_SEL_STATS_EN
    chk("rst_if_cnt_a", ic_a, '0);
`endif
    @(posedge clk);
    #2 reset = 1'b1;
    q.delete();
    for (int k = 0; k < 3; k++) begin exp_ifc[k] = 0; exp_elc[k] = 0; end
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", ir_a, 1'b1);
    chk("post_rst_out_valid", ov_a, 1'b0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [31:0]  ibit;
    logic [3:0]   fa;
    logic [3:0]   fb;
    logic [127:0] da;
    logic [127:0] db;
  } vec_t;

  vec_t tbl[4];

  initial begin
    logic acc;
    int   sent;
    logic [127:0] ra, rb;

    tbl[0] = '{32'h0000_0005, 4'b0101, 4'b0000,
               {32'h5555_0003, 32'hAAAA_0002, 32'h5555_0001, 32'hAAAA_0000}, ELSE_ALL};
    tbl[1] = '{32'h0000_0010, 4'b0000, 4'b1111, ELSE_ALL, IF_ALL};
    tbl[2] = '{32'h0000_000F, 4'b1111, 4'b0000, IF_ALL, ELSE_ALL};
    tbl[3] = '{32'hFFFF_FFFA, 4'b1010, 4'b1111,
               {32'hAAAA_0003, 32'h5555_0002, 32'hAAAA_0001, 32'h5555_0000}, IF_ALL};

    in_valid = 1'b0; out_ready = 1'b1; input_bit = '0; if_d = '0; else_d = '0;
    do_reset();

    // Single beats: not visible after the accepting edge, visible after the next.
    for (int v = 0; v < 4; v++) begin
      in_valid = 1'b1; input_bit = tbl[v].ibit; if_d = IF_ALL; else_d = ELSE_ALL;
      out_ready = 1'b1;
      #1;
      chk("tbl_in_ready", ir_a, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0; input_bit = '0; if_d = '0; else_d = '0;
      chk("tbl_lat1_out_valid", ov_a, 1'b0);
      @(posedge clk); #1;
      chk("tbl_lat2_out_valid", ov_a, 1'b1);
      chk("tbl_flags_a", cf_a, tbl[v].fa);
      chk("tbl_data_a", sc_a, tbl[v].da);
      chk("tbl_flags_b", cf_b, tbl[v].fb);
      chk("tbl_data_b", sc_b, tbl[v].db);
      chk("tbl_flags_c", cf_c, 4'b0000);
      chk("tbl_data_c", sc_c, ELSE_ALL);
      @(posedge clk); #1;
      chk("tbl_drained", ov_a, 1'b0);
    end

    do_reset();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom, ra, rb, acc);
    end
    for (int n = 0; n < 5; n++) step(1'b0, 1'b1, '0, '0, '0, acc);

    // Eight back-to-back beats, out_ready pattern 1,0,0 repeating.
    sent = 0;
    for (int k = 0; k < 60; k++) begin
      ra = {4{24'hC0FFEE, 8'(k)}};
      rb = {4{24'hBEEF00, 8'(k)}};
      step(sent < 8, (k % 3) == 0, $urandom, ra, rb, acc);
      if (acc) sent++;
    end
    chk("b2b_all_sent", sent, 8);
    chk("b2b_drained", ov_a, 1'b0);

    // Reset mid-flight with two beats held in the pipe.
    step(1'b1, 1'b0, 32'h5, IF_ALL, ELSE_ALL, acc);
    step(1'b1, 1'b0, 32'hA, IF_ALL, ELSE_ALL, acc);
    chk("inflight_full", ir_a, 1'b0);
    in_valid = 1'b0;
    do_reset();
    for (int n = 0; n < 4; n++) step(1'b0, 1'b1, '0, '0, '0, acc);
    // First beat after reset: nominal latency, checked by the model.
    step(1'b1, 1'b1, 32'h3, IF_ALL, ELSE_ALL, acc);
    for (int n = 0; n < 4; n++) step(1'b0, 1'b1, '0, '0, '0, acc);

`ifdef IF_ELSE_PIPE_SEL_STATS_EN
    do_reset();
    for (int n = 0; n < 20000; n++) step(1'b1, 1'b1, 32'hF, IF_ALL, ELSE_ALL, acc);
    for (int n = 0; n < 3; n++) step(1'b0, 1'b1, '0, '0, '0, acc);
    chk("sat_if_count", ic_a, 16'hFFFF);
    chk("sat_else_count", ec_a, 16'h0000);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
